mem_stage_controller: RTL and testbench

- Sequences the data-memory access of the MEM stage in the five-stage RISC-V pipeline.
- Turns the MEM-stage MemRead/MemWrite controls into a req/ack transaction to a multi-cycle data memory.
- Freezes the upstream pipeline while the transaction is outstanding, then presents the load data and a capture enable to the mem_wb_pipe register.
- Suppresses writeback (bubble) on misaligned, flushed or timed-out accesses.

---
 rtl/mem_stage_controller.sv | 105 ++++++++++
 tb/tb_mem_stage_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_controller.sv
// mem_stage_controller: MEM-stage req/ack data-memory sequencer with pipeline stall and writeback bubble control
module mem_stage_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              flush,
  input  logic [ADDR_W-1:0] address_in,
  input  logic [DATA_W-1:0] write_data_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              memwb_en,
  output logic              bubble,
  output logic [DATA_W-1:0] read_data_out,
  output logic              misalign_err,
  output logic              timeout_err
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic abort, kill, ctrl, access, aligned, last, start;
  assign ctrl = MemRead_in | MemWrite_in;
  assign access = ctrl & ~flush;
  assign aligned = address_in[1:0] == 2'b00;
  assign start = state == IDLE && access && aligned;
  assign last = cnt == CW'(TIMEOUT - 1);
  assign mem_req = state == ACCESS;
  always_comb begin
    state_nx = state;
    stall = 1'b0;
    memwb_en = 1'b1;
    bubble = 1'b0;
    misalign_err = 1'b0;
    unique case (state)
      IDLE: begin
        stall = access & aligned;
        memwb_en = ~(access & aligned);
        bubble = ctrl & (flush | ~aligned);
        misalign_err = access & ~aligned;
        state_nx = (access & aligned) ? ACCESS : IDLE;
      end
      ACCESS: begin
        stall = 1'b1;
        memwb_en = 1'b0;
        state_nx = (mem_ack | last) ? DONE : ACCESS;
      end
      DONE: begin
        bubble = abort | kill;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Hold the pipeline-facing outputs at their idle values while in reset
    if (!reset) begin
      stall = 1'b0;
      memwb_en = 1'b1;
      bubble = 1'b0;
      misalign_err = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      read_data_out <= '0;
      timeout_err <= 1'b0;
      cnt <= '0;
      abort <= 1'b0;
      kill <= 1'b0;
    end else begin
      state <= state_nx;
      if (start) begin
        mem_addr <= address_in;
        mem_wdata <= write_data_in;
        mem_we <= MemWrite_in;
        cnt <= '0;
        abort <= 1'b0;
        kill <= 1'b0;
      end
      if (state == ACCESS) begin
        if (flush) kill <= 1'b1;
        if (mem_ack) begin
          if (!mem_we) read_data_out <= mem_rdata;
        end else if (last) begin
          abort <= 1'b1;
          timeout_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_controller.sv
// tb_mem_stage_controller: vector table, directed corner cases and random transactions against a transaction-level model
module tb_mem_stage_controller;
  localparam int AW = 32, DW = 32, TO = 16;
  logic clk = 1'b0, reset = 1'b0;
  logic MemRead_in = 1'b0, MemWrite_in = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] address_in = '0;
  logic [DW-1:0] write_data_in = '0, mem_rdata = '0;
  logic mem_req, mem_we, stall, memwb_en, bubble, misalign_err, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, read_data_out;
  int total = 0, bad = 0;
  logic [DW-1:0] m_rdata = '0;
  logic m_terr = 1'b0;

  always #5 clk = ~clk;

  mem_stage_controller #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .flush(flush), .address_in(address_in), .write_data_in(write_data_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .memwb_en(memwb_en),
    .bubble(bubble), .read_data_out(read_data_out), .misalign_err(misalign_err),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead_in = 1'b0;
    MemWrite_in = 1'b0;
    flush = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req"}, 64'(mem_req), 64'(0));
    chk({tag, "_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_rdo"}, 64'(read_data_out), 64'(0));
    chk({tag, "_terr"}, 64'(timeout_err), 64'(0));
    chk({tag, "_stall"}, 64'(stall), 64'(0));
    chk({tag, "_en"}, 64'(memwb_en), 64'(1));
    chk({tag, "_bub"}, 64'(bubble), 64'(0));
    chk({tag, "_mis"}, 64'(misalign_err), 64'(0));
  endtask

  // One MEM-stage instruction; d = ACCESS cycle index carrying the ack, kill_at = ACCESS cycle index carrying flush
  task automatic run_txn(input logic rd, input logic wr, input logic fl, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rdv, input int d, input int kill_at);
    int n, reqs, stalls;
    logic kill, to, done, d_bub, d_terr;
    logic [DW-1:0] d_rdo;
    @(posedge clk); #1;
    MemRead_in = rd; MemWrite_in = wr; flush = fl; address_in = a;
    write_data_in = wd; mem_rdata = rdv; mem_ack = 1'b0;
    if (fl) begin
      #1;
      chk("flush_issue_bub", 64'(bubble), 64'(1));
      chk("flush_issue_en", 64'(memwb_en), 64'(1));
      chk("flush_issue_stall", 64'(stall), 64'(0));
      @(posedge clk); #1; idle_inputs(); #1;
      chk("flush_issue_noreq", 64'(mem_req), 64'(0));
      return;
    end
    if (a[1:0] != 2'b00) begin
      #1;
      chk("mis_err", 64'(misalign_err), 64'(1));
      chk("mis_bub", 64'(bubble), 64'(1));
      chk("mis_stall", 64'(stall), 64'(0));
      chk("mis_en", 64'(memwb_en), 64'(1));
      @(posedge clk); #1; idle_inputs(); #1;
      chk("mis_pulse_end", 64'(misalign_err), 64'(0));
      chk("mis_noreq", 64'(mem_req), 64'(0));
      return;
    end
    n = d < TO ? d + 1 : TO;
    to = d >= TO;
    kill = kill_at < n;
    reqs = 0; stalls = 0; done = 1'b0;
    d_bub = 1'b0; d_terr = 1'b0; d_rdo = '0;
    for (int i = 0; i < TO + 8 && !done; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      mem_ack = (i - 1 == d);
      flush = (i - 1 == kill_at);
      #1;
      reqs += int'(mem_req);
      stalls += int'(stall);
      if (mem_req) begin
        chk("fld_addr", 64'(mem_addr), 64'(a));
        chk("fld_we", 64'(mem_we), 64'(wr));
        chk("fld_wdata", 64'(mem_wdata), 64'(wd));
      end
      if (i > 0 && memwb_en) begin
        done = 1'b1;
        d_bub = bubble; d_rdo = read_data_out; d_terr = timeout_err;
        chk("done_stall", 64'(stall), 64'(0));
      end
    end
    idle_inputs();
    if (!to && !wr) m_rdata = rdv;
    if (to) m_terr = 1'b1;
    chk("done_seen", 64'(done), 64'(1));
    chk("req_cycles", 64'(reqs), 64'(n));
    chk("stall_cycles", 64'(stalls), 64'(n + 1));
    chk("done_bubble", 64'(d_bub), 64'(to | kill));
    chk("done_rdata", 64'(d_rdo), 64'(m_rdata));
    chk("done_terr", 64'(d_terr), 64'(m_terr));
  endtask

  typedef struct {
    logic rd, wr, fl;
    logic [1:0] lo;
    logic st, en, bu, mi;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1};

    #12;
    check_reset_state("rst");
    @(negedge clk) reset = 1'b1;

    foreach (tbl[k]) begin
      @(posedge clk); #1;
      MemRead_in = tbl[k].rd; MemWrite_in = tbl[k].wr; flush = tbl[k].fl;
      address_in = 32'h400 | 32'(tbl[k].lo);
      #1;
      chk($sformatf("vec%0d_stall", k), 64'(stall), 64'(tbl[k].st));
      chk($sformatf("vec%0d_en", k), 64'(memwb_en), 64'(tbl[k].en));
      chk($sformatf("vec%0d_bub", k), 64'(bubble), 64'(tbl[k].bu));
      chk($sformatf("vec%0d_mis", k), 64'(misalign_err), 64'(tbl[k].mi));
      #1 idle_inputs();
    end
    @(posedge clk); #2;
    chk("vec_no_req", 64'(mem_req), 64'(0));

    run_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 99);
    run_txn(1'b0, 1'b1, 1'b0, 32'h204, 32'h12345678, 32'h55555555, 0, 99);
    run_txn(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 32'h0, 0, 99);
    run_txn(1'b1, 1'b0, 1'b0, 32'h108, 32'h0, 32'hCAFEF00D, 2, 0);
    run_txn(1'b1, 1'b0, 1'b0, 32'h10C, 32'h0, 32'hA5A5A5A5, TO - 1, 99);
    run_txn(1'b1, 1'b0, 1'b0, 32'h110, 32'h0, 32'h0BADBAD0, TO, 99);
    @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clk); #1; mem_ack = 1'b0; #1;
    chk("late_ack_rdo", 64'(read_data_out), 64'(m_rdata));
    chk("late_ack_req", 64'(mem_req), 64'(0));
    chk("late_ack_terr", 64'(timeout_err), 64'(1));
    run_txn(1'b1, 1'b0, 1'b0, 32'h114, 32'h0, 32'h13579BDF, 1, 99);

    for (int t = 0; t < 40; t++) begin
      logic [1:0] op;
      logic [31:0] r;
      int d;
      op = 2'($urandom_range(0, 2));
      r = $urandom;
      r[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom_range(0, 5));
      run_txn(op != 2'd1, op != 2'd0, $urandom_range(0, 9) == 0, r, $urandom, $urandom,
              d, int'($urandom_range(0, 12)));
    end

    @(posedge clk); #1;
    MemRead_in = 1'b1; address_in = 32'h300;
    @(posedge clk); #1;
    chk("mid_rst_req_before", 64'(mem_req), 64'(1));
    #1 reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    #1;
    check_reset_state("mid_rst");
    m_rdata = '0; m_terr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_state("rst_ack_ignored");
    idle_inputs();
    @(negedge clk) reset = 1'b1;
    run_txn(1'b1, 1'b0, 1'b0, 32'h304, 32'h0, 32'h2468ACE0, 3, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
